// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one operation in flight, result handed to the register-file write port via valid/ready.
module mdu #(
    parameter int XLEN = 32,
    parameter int ID_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [ID_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_rd,
    output logic [XLEN-1:0] out_wdata
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [ID_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    // Operand decode at acceptance
    logic            a_signed, b_signed, sa, sb, is_div, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign sa       = a_signed & in_rs1[XLEN-1];
    assign sb       = b_signed & in_rs2[XLEN-1];
    assign a_mag    = sa ? -in_rs1 : in_rs1;
    assign b_mag    = sb ? -in_rs2 : in_rs2;
    assign is_div   = in_funct3[2];
    assign is_rem   = in_funct3[2] & in_funct3[1];
    assign div_zero = is_div && (in_rs2 == '0);
    assign div_ovf  = is_div && !in_funct3[0] && (in_rs1 == MIN_NEG) && (in_rs2 == '1);

    always_comb begin
        if (div_zero) special_res = in_funct3[1] ? in_rs1 : '1;
        else          special_res = in_funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, prod_fix;
    logic [XLEN-1:0]   quo, rem, calc_res;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    assign mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, op_q};
    assign div_acc   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign step_acc  = f3_q[2] ? div_acc : mul_acc;

    assign prod_fix = neg_q ? -step_acc : step_acc;
    assign quo      = step_acc[XLEN-1:0];
    assign rem      = step_acc[2*XLEN-1:XLEN];

    always_comb begin
        case (f3_q)
            3'b000:                 calc_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = neg_q ? -quo : quo;
            default:                calc_res = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        f3_d  = in_funct3;
                        rd_d  = in_rd;
                        neg_d = is_rem ? sa : (sa ^ sb);
                        cnt_d = '0;
                        acc_d = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        op_d  = is_div ? b_mag : a_mag;
                        if (div_zero || div_ovf) begin
                            wdata_d = special_res;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        wdata_d = calc_res;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_rd    = rd_q;
    assign out_wdata = wdata_q;
endmodule
